// File: rtl/serial_full_sub_pkg.sv
// Shared types and helpers for the bit-serial full subtractor.
package serial_full_sub_pkg;

  // Sequencer states: wait for work, shift bits through the cell, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1. Never returns less than 1, so WIDTH=1 still
  // gets a legal one-bit counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((r < 32) && ((32'd1 << r) < n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: x - y - c.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic diff,
  output logic bout
);

  // Difference bit, and borrow when y+c exceeds x.
  always_comb begin
    diff = x ^ y ^ c;
    bout = (~x & y) | (~(x ^ y) & c);
  end

endmodule

// File: rtl/serial_full_sub.sv
// Bit-serial WIDTH-bit subtractor, d = a - b - bin, one bit per clock, LSB first.
module serial_full_sub
  import serial_full_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             br
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_shift;
  logic             borrow_q;
  logic             cell_diff;
  logic             cell_bout;
  logic             last_bit;

  full_sub_cell u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .c    (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // Result register with this cycle's diff bit entering at the MSB.
  always_comb begin
    res_shift = (res_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shift registers, running borrow and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      sa_q     <= a;
      sb_q     <= b;
      res_q    <= '0;
      borrow_q <= bin;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      sa_q     <= sa_q >> 1;
      sb_q     <= sb_q >> 1;
      res_q    <= res_shift;
      borrow_q <= cell_bout;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Registered handshake and result; d/br move only when done rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      d    <= '0;
      br   <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      if ((state_q == RUN) && last_bit) begin
        d  <= res_shift;
        br <= cell_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_full_sub.sv
// Directed bench for serial_full_sub at WIDTH 8, 4 and 1, plus the stand-alone cell.
module tb_serial_full_sub;

  logic clk;
  logic rst;

  logic       start8, bin8, busy8, done8, br8;
  logic [7:0] a8, b8, d8;
  logic       start4, bin4, busy4, done4, br4;
  logic [3:0] a4, b4, d4;
  logic       start1, bin1, busy1, done1, br1;
  logic [0:0] a1, b1, d1;
  logic       cx, cy, cc, cdiff, cbout;

  int n_checks;
  int n_fail;

  serial_full_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .br(br8)
  );

  serial_full_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .br(br4)
  );

  serial_full_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .br(br1)
  );

  full_sub_cell u_cell (
    .x(cx), .y(cy), .c(cc), .diff(cdiff), .bout(cbout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy8, done8, d8, br8} !== 11'd0) begin
      n_fail++; $display("FAIL reset_hold: got %h expected 0", {busy8, done8, d8, br8});
    end
    n_checks++;
    if ({busy4, done4, d4, br4, busy1, done1, d1, br1} !== 11'd0) begin
      n_fail++; $display("FAIL reset_hold_small: got %h expected 0",
                         {busy4, done4, d4, br4, busy1, done1, d1, br1});
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({busy8, done8, d8, br8} !== 11'd0) begin
        n_fail++; $display("FAIL idle_after_reset cyc %0d: got %h expected 0", i, {busy8, done8, d8, br8});
      end
    end
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      input logic [7:0] ed, input logic eb, input string nm);
    int n;
    a8 = ai; b8 = bi; bin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", nm, busy8);
    end
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_fail++; $display("FAIL %s latency: got %0d expected 8", nm, n);
    end
    n_checks++;
    if (d8 !== ed || br8 !== eb) begin
      n_fail++; $display("FAIL %s result: got d=%h br=%b expected d=%h br=%b", nm, d8, br8, ed, eb);
    end
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", nm, busy8);
    end
    tick();
    n_checks++;
    if (done8 !== 1'b0 || d8 !== ed) begin
      n_fail++; $display("FAIL %s done_pulse_end: got done=%b d=%h expected done=0 d=%h", nm, done8, d8, ed);
    end
  endtask

  task automatic test_basic();
    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "sub_5_3");
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "sub_3_5");
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "sub_0_0_bin");
  endtask

  task automatic test_back_to_back();
    int t, last, n, ai, bi, ci;
    logic [8:0] v;
    logic [3:0] ed;
    logic       eb;
    v = 9'd0;
    a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0]; start4 = 1'b1;
    tick();
    t = 0;
    last = 0;
    for (int i = 0; i < 512; i++) begin
      v  = 9'(i);
      ai = int'(v[8:5]);
      bi = int'(v[4:1]);
      ci = int'(v[0]);
      ed = 4'(ai - bi - ci);
      eb = (ai < bi + ci);
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        tick();
        t++;
        n++;
      end
      n_checks++;
      if (n != 4) begin
        n_fail++; $display("FAIL exh4 latency op %0d: got %0d expected 4", i, n);
      end
      if (i > 0) begin
        n_checks++;
        if (t - last != 5) begin
          n_fail++; $display("FAIL exh4 done_spacing op %0d: got %0d expected 5", i, t - last);
        end
      end
      last = t;
      n_checks++;
      if (d4 !== ed || br4 !== eb) begin
        n_fail++; $display("FAIL exh4 op %0d a=%0d b=%0d bin=%0d: got d=%h br=%b expected d=%h br=%b",
                           i, ai, bi, ci, d4, br4, ed, eb);
      end
      if (i < 511) begin
        v = 9'(i + 1);
        a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0];
      end else begin
        start4 = 1'b0;
      end
      tick();
      t++;
    end
    n_checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL exh4 final_idle: got done=%b busy=%b expected 0 0", done4, busy4);
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL midrun_start pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (d8 !== 8'h7F || br8 !== 1'b0) begin
      n_fail++; $display("FAIL midrun_start result: got d=%h br=%b expected d=7f br=0", d8, br8);
    end
  endtask

  task automatic test_reset_midrun();
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL rst_midrun busy_before: got %b expected 1", busy8);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, d8, br8} !== 11'd0) begin
      n_fail++; $display("FAIL rst_midrun clear: got %h expected 0", {busy8, done8, d8, br8});
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (done8 !== 1'b0) begin
      n_fail++; $display("FAIL rst_midrun no_done: got %b expected 0", done8);
    end
    run8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, "after_rst");
  endtask

  task automatic test_width1();
    logic [7:0] dtab, btab;
    logic [2:0] v;
    dtab = 8'b1001_0110;
    btab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++; $display("FAIL w1 run %0d: got busy=%b done=%b expected 1 0", i, busy1, done1);
      end
      tick();
      n_checks++;
      if (done1 !== 1'b1 || d1[0] !== dtab[i] || br1 !== btab[i]) begin
        n_fail++; $display("FAIL w1 result %0d: got done=%b d=%b br=%b expected 1 %b %b",
                           i, done1, d1, br1, dtab[i], btab[i]);
      end
      tick();
    end
  endtask

  task automatic test_cell();
    logic [7:0] dtab, btab;
    logic [2:0] v;
    dtab = 8'b1001_0110;
    btab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      cx = v[2]; cy = v[1]; cc = v[0];
      #1;
      n_checks++;
      if (cdiff !== dtab[i] || cbout !== btab[i]) begin
        n_fail++; $display("FAIL cell %0d: got diff=%b bout=%b expected %b %b",
                           i, cdiff, cbout, dtab[i], btab[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    cx = 1'b0; cy = 1'b0; cc = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_midrun();
    test_width1();
    test_cell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
